toggle_cover_collector: RTL and testbench
=========================================

Name: toggle_cover_collector

Overview:
- Upstream producer for the per-bit toggle-cover sink (the module that issues one coverage call per set bit of its 62-bit valid input).
- Samples a vector of monitored design signals and detects rising and falling transitions.
- Filters transitions to first-hit only, so each cover point pulses exactly once until cleared.
- Keeps a covered bitmap and a saturating covered-point count for in-simulation and formal progress reporting.

Parameters:
- WIDTH, 31, number of monitored signal bits; output vector width is 2*WIDTH (62 at default).
- COUNT_W, 16, width of the covered-point counter.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- sig  input  WIDTH  monitored signals, sampled every rising clock edge.
- en  input  1  sampling enable.
- clear  input  1  synchronous clear of coverage state.
- valid  output  2*WIDTH  one-cycle pulses for newly covered points; feeds the sink's valid input.
- covered  output  2*WIDTH  sticky covered bitmap.
- cover_count  output  COUNT_W  number of covered points, saturating.
- all_covered  output  1  high when every covered bit is 1.

Behaviour:
- Bit mapping:
  - valid[2i] / covered[2i] = rise of sig[i] (previous sample 0, current sample 1).
  - valid[2i+1] / covered[2i+1] = fall of sig[i] (previous sample 1, current sample 0).
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - prev=0, valid=0, covered=0, cover_count=0, all_covered=0.
- States: IDLE, PRIME, RUN. The `prev` register is meaningful only in RUN.
  - IDLE: en=1 -> PRIME. Otherwise stay in IDLE; no detection.
  - PRIME: capture prev<=sig, no detection, valid=0 next cycle; -> RUN if en, else IDLE.
  - RUN with en=1: compute hit = edges & ~covered.
    - Registered outputs: valid<=hit, covered<=covered|hit, prev<=sig.
    - cover_count <= min(cover_count + popcount(hit), 2^COUNT_W-1).
  - RUN with en=0: -> IDLE; valid<=0; covered and cover_count retained.
  - Re-enable after IDLE always passes through PRIME, so no stale-edge reports.
- Latency: a transition between sampling edges n-1 and n appears on valid during the cycle after edge n. valid is a single-cycle pulse.
- clear=1 (any state, highest priority after reset):
  - valid<=0, covered<=0, cover_count<=0, all_covered<=0.
  - Edges present in the same cycle are discarded, not reported.
  - Next state: PRIME if en, else IDLE.
- Simultaneous rise and fall of different bits in one cycle: all reported in the same valid word; popcount covers every new bit.
- Already-covered points never re-pulse until clear or reset.
- Saturation: cover_count holds at all-ones and never wraps. Reachable only if 2*WIDTH >= 2^COUNT_W; include it anyway.
- all_covered is registered from the next-state covered value, so it rises in the same cycle covered becomes all-ones.
- sig is treated as synchronous to clock; no internal synchronizers.
- Reset mid-RUN: all outputs drop asynchronously; state returns to IDLE.
- DPI/coverage calls belong to the sink, not to this block; this block is synthesizable RTL.

Decomposition:
- Package toggle_cover_pkg:
  - state enum {IDLE, PRIME, RUN}.
  - Index helpers rise_idx(i)=2i and fall_idx(i)=2i+1.
  - Saturating-add function parameterized by COUNT_W.
- Sub-module toggle_popcount:
  - Parameterized-width combinational adder tree returning the count of set bits in hit.
  - Output width clog2(2*WIDTH+1).

Test Plan:
- Reset, then en=1, sig=0 -> PRIME cycle gives valid=0. Set sig[0]=1 -> next cycle valid=62'h1, cover_count=1; following cycle valid=0.
- Toggle sig[0] 1->0->1->0 -> valid[1] pulses once on the first fall. The second rise and second fall produce no pulse. cover_count=2, covered=62'h3.
- From a covered state with cover_count=5, assert clear in the same cycle sig[3] rises -> valid=0, covered=0, cover_count=0. The sig[3] edge is not reported; a later sig[3] fall reports valid[7].
- Drive sig=31'h7FFFFFFF then 0 then all-ones again -> first word valid=62'h1555...5 (all even bits). Second word has all odd bits set. cover_count=62, all_covered=1 in the cycle the last bits land.
- en=1, sig[2]=0; drop en, set sig[2]=1, re-raise en -> PRIME absorbs the change, valid stays 0. A subsequent sig[2] fall reports valid[5].
- Assert reset=0 mid-RUN with covered nonzero -> valid, covered, cover_count and all_covered read 0 before the next clock edge. After release with en=1, the block passes through PRIME before any detection.

Source files
------------

// File: rtl/toggle_cover_pkg.sv
// Shared types and helpers for the toggle-cover collector: FSM states,
// cover-point index mapping and a saturating counter add.
package toggle_cover_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_e;

   function automatic int rise_idx(input int i);
      return 2 * i;
   endfunction

   function automatic int fall_idx(input int i);
      return 2 * i + 1;
   endfunction

   // Clamps at 2^cw-1; valid for cw up to 32.
   function automatic logic [32:0] sat_add(input logic [31:0] acc,
                                           input logic [31:0] inc,
                                           input int          cw);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, acc} + {1'b0, inc};
      lim = (33'd1 << cw) - 33'd1;
      return (sum > lim) ? lim : sum;
   endfunction

endpackage

// File: rtl/toggle_popcount.sv
// Combinational set-bit counter built as a balanced binary adder tree.
// Latency 0; no backpressure (pure function of the input word).
module toggle_popcount #(
   parameter int W  = 62,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  bits,
   output logic [CW-1:0] cnt
);

   // Leaves padded to a power of two; heap layout, node k sums nodes 2k and 2k+1.
   localparam int N = 1 << $clog2(W);

   logic [CW-1:0] node [1:2*N-1];

   genvar j, k;
   generate
      for (j = 0; j < N; j++) begin : g_leaf
         if (j < W) begin : g_bit
            assign node[N+j] = CW'(bits[j]);
         end else begin : g_pad
            assign node[N+j] = '0;
         end
      end
      for (k = 1; k < N; k++) begin : g_sum
         assign node[k] = node[2*k] + node[2*k+1];
      end
   endgenerate

   assign cnt = node[1];

endmodule

// File: rtl/toggle_cover_collector.sv
// First-hit rise/fall toggle detector feeding the per-bit cover sink, with sticky bitmap and saturating count.
// Latency: edge at sample n pulses valid the cycle after edge n; no backpressure (sink must accept every pulse).
module toggle_cover_collector
   import toggle_cover_pkg::*;
#(
   parameter int WIDTH   = 31,
   parameter int COUNT_W = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     sig,
   input  logic                 en,
   input  logic                 clear,
   output logic [2*WIDTH-1:0]   valid,
   output logic [2*WIDTH-1:0]   covered,
   output logic [COUNT_W-1:0]   cover_count,
   output logic                 all_covered
);

   localparam int NPTS = 2 * WIDTH;
   localparam int PW   = $clog2(NPTS + 1);

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    prev_q, prev_d;
   logic [NPTS-1:0]     valid_q, valid_d;
   logic [NPTS-1:0]     covered_q, covered_d;
   logic [COUNT_W-1:0]  count_q, count_d;
   logic                all_q, all_d;

   logic [NPTS-1:0]     edges;
   logic [NPTS-1:0]     hit;
   logic [PW-1:0]       hit_cnt;

   always_comb begin
      edges = '0;
      for (int i = 0; i < WIDTH; i++) begin
         edges[rise_idx(i)] = ~prev_q[i] &  sig[i];
         edges[fall_idx(i)] =  prev_q[i] & ~sig[i];
      end
      hit = edges & ~covered_q;
   end

   toggle_popcount #(
      .W  (NPTS),
      .CW (PW)
   ) u_popcount (
      .bits (hit),
      .cnt  (hit_cnt)
   );

   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      valid_d   = '0;
      covered_d = covered_q;
      count_d   = count_q;

      if (clear) begin
         // Same-cycle edges are dropped; re-entry goes through PRIME.
         covered_d = '0;
         count_d   = '0;
         state_d   = en ? PRIME : IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (en) state_d = PRIME;
            end
            PRIME: begin
               prev_d  = sig;
               state_d = en ? RUN : IDLE;
            end
            RUN: begin
               if (en) begin
                  valid_d   = hit;
                  covered_d = covered_q | hit;
                  prev_d    = sig;
                  count_d   = COUNT_W'(sat_add(32'(count_q), 32'(hit_cnt), COUNT_W));
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      all_d = &covered_d;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         prev_q    <= '0;
         valid_q   <= '0;
         covered_q <= '0;
         count_q   <= '0;
         all_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         valid_q   <= valid_d;
         covered_q <= covered_d;
         count_q   <= count_d;
         all_q     <= all_d;
      end
   end

   assign valid       = valid_q;
   assign covered     = covered_q;
   assign cover_count = count_q;
   assign all_covered = all_q;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Randomized and directed checks of toggle_cover_collector against a bit-level reference model.
module tb_toggle_cover_collector;

   localparam int WIDTH = 31;
   localparam int NPTS  = 2 * WIDTH;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [WIDTH-1:0]  sig   = '0;
   logic              en    = 1'b0;
   logic              clear = 1'b0;

   logic [NPTS-1:0]   valid, covered;
   logic [15:0]       cover_count;
   logic              all_covered;

   logic [NPTS-1:0]   s_valid, s_covered;
   logic [4:0]        s_count;
   logic              s_all;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   toggle_cover_collector #(.WIDTH(WIDTH), .COUNT_W(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .sig         (sig),
      .en          (en),
      .clear       (clear),
      .valid       (valid),
      .covered     (covered),
      .cover_count (cover_count),
      .all_covered (all_covered)
   );

   // Narrow counter so saturation is reachable with 62 points.
   toggle_cover_collector #(.WIDTH(WIDTH), .COUNT_W(5)) dut_sat (
      .clock       (clock),
      .reset       (reset),
      .sig         (sig),
      .en          (en),
      .clear       (clear),
      .valid       (s_valid),
      .covered     (s_covered),
      .cover_count (s_count),
      .all_covered (s_all)
   );

   // Reference model: mode 0 = disabled, 1 = priming, 2 = detecting.
   int               m_mode;
   bit [WIDTH-1:0]   m_prev;
   bit [NPTS-1:0]    m_val, m_cov;
   int               m_cnt, m_cnt5;
   bit               m_all;

   function automatic void model_reset();
      m_mode = 0; m_prev = '0; m_val = '0; m_cov = '0;
      m_cnt = 0; m_cnt5 = 0; m_all = 1'b0;
   endfunction

   function automatic void model_clk(input bit [WIDTH-1:0] s, input bit e, input bit c);
      bit [NPTS-1:0] nv;
      nv = '0;
      if (c) begin
         m_cov = '0; m_cnt = 0; m_cnt5 = 0; m_val = '0;
         m_mode = e ? 1 : 0;
      end else if (m_mode == 0) begin
         m_val = '0;
         if (e) m_mode = 1;
      end else if (m_mode == 1) begin
         m_val  = '0;
         m_prev = s;
         m_mode = e ? 2 : 0;
      end else if (e) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (!m_prev[i] && s[i] && !m_cov[2*i])     nv[2*i]   = 1'b1;
            if (m_prev[i] && !s[i] && !m_cov[2*i+1])   nv[2*i+1] = 1'b1;
         end
         for (int b = 0; b < NPTS; b++) begin
            if (nv[b]) begin
               m_cov[b] = 1'b1;
               if (m_cnt  < 65535) m_cnt++;
               if (m_cnt5 < 31)    m_cnt5++;
            end
         end
         m_val  = nv;
         m_prev = s;
      end else begin
         m_val  = '0;
         m_mode = 0;
      end
      m_all = (m_cov == {NPTS{1'b1}});
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("valid",       64'(valid),       64'(m_val));
      chk("covered",     64'(covered),     64'(m_cov));
      chk("cover_count", 64'(cover_count), 64'(m_cnt));
      chk("all_covered", 64'(all_covered), 64'(m_all));
      chk("sat_count",   64'(s_count),     64'(m_cnt5));
      chk("sat_valid",   64'(s_valid),     64'(m_val));
   endtask

   // Advance one edge with the currently driven inputs, then compare.
   task automatic tick();
      @(posedge clock);
      model_clk(sig, en, clear);
      #1;
      check_all();
   endtask

   task automatic async_reset_check();
      @(negedge clock);
      reset = 1'b0;
      #1;
      model_reset();
      chk("rst_valid",   64'(valid),       64'd0);
      chk("rst_covered", 64'(covered),     64'd0);
      chk("rst_count",   64'(cover_count), 64'd0);
      chk("rst_all",     64'(all_covered), 64'd0);
      #2;
      reset = 1'b1;
   endtask

   initial begin
      logic [NPTS-1:0] exp_even, exp_odd;
      exp_even = 62'h1555_5555_5555_5555;
      exp_odd  = 62'h2AAA_AAAA_AAAA_AAAA;
      model_reset();

      #3;
      chk("init_valid",   64'(valid),       64'd0);
      chk("init_covered", 64'(covered),     64'd0);
      chk("init_count",   64'(cover_count), 64'd0);
      chk("init_all",     64'(all_covered), 64'd0);
      @(negedge clock);
      reset = 1'b1;

      // First rise of sig[0] after priming.
      en = 1'b1; sig = '0;
      tick(); tick();
      chk("prime_valid", 64'(valid), 64'd0);
      sig[0] = 1'b1; tick();
      chk("first_rise", 64'(valid), 64'h1);
      chk("first_cnt",  64'(cover_count), 64'd1);
      tick();
      chk("pulse_drop", 64'(valid), 64'd0);

      // Repeated toggles of sig[0]: only the first fall reports.
      sig[0] = 1'b0; tick();
      chk("first_fall", 64'(valid), 64'h2);
      sig[0] = 1'b1; tick();
      sig[0] = 1'b0; tick();
      chk("no_repulse", 64'(valid), 64'd0);
      chk("cov_03",     64'(covered), 64'h3);
      chk("cnt_2",      64'(cover_count), 64'd2);

      // Reach count 5, then clear coincident with a sig[3] rise.
      sig[1] = 1'b1; tick();
      sig[1] = 1'b0; tick();
      sig[2] = 1'b1; tick();
      chk("cnt_5", 64'(cover_count), 64'd5);
      clear = 1'b1; sig[3] = 1'b1; tick();
      chk("clr_valid", 64'(valid), 64'd0);
      chk("clr_cov",   64'(covered), 64'd0);
      chk("clr_cnt",   64'(cover_count), 64'd0);
      clear = 1'b0; tick(); tick();
      chk("clr_no_stale", 64'(valid), 64'd0);
      sig[3] = 1'b0; tick();
      chk("fall3", 64'(valid), 64'h80);

      // Full-width rise then fall: every point covered.
      clear = 1'b1; sig = '0; tick();
      clear = 1'b0; tick();
      sig = '1; tick();
      chk("all_rise", 64'(valid), 64'(exp_even));
      chk("all_rise_notall", 64'(all_covered), 64'd0);
      sig = '0; tick();
      chk("all_fall", 64'(valid), 64'(exp_odd));
      chk("cnt_62",   64'(cover_count), 64'd62);
      chk("all_cov",  64'(all_covered), 64'd1);
      chk("sat_31",   64'(s_count), 64'd31);

      // Enable drop: PRIME absorbs the change made while disabled.
      clear = 1'b1; tick();
      clear = 1'b0; tick(); tick();
      en = 1'b0; tick();
      sig[2] = 1'b1; tick();
      en = 1'b1; tick(); tick(); tick();
      chk("reen_quiet", 64'(valid), 64'd0);
      sig[2] = 1'b0; tick();
      chk("reen_fall2", 64'(valid), 64'h20);

      // Reset mid-run with coverage held, then reprime.
      async_reset_check();
      sig = '1; tick(); tick();
      chk("post_rst_prime", 64'(valid), 64'd0);
      sig = '0; tick();

      // Random traffic with occasional clear, enable drops and resets.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 3) == 0)
            sig = sig ^ WIDTH'($urandom);
         else
            sig = sig ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
         en    = ($urandom_range(0, 9) != 0);
         clear = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 299) == 0) async_reset_check();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
